prio_encoder_7seg_seq: RTL

Registered, parametrised priority encoder with hexadecimal 7-segment output. It is the sequential successor of the combinational 8-bit priority encoder / 7-segment decoder. The block takes up to 16 asynchronous input lines and synchronises them. It reports the index of the highest set bit as a hex digit, and offers a latch mode that captures and holds the first non-zero event until it is cleared. It sits between the raw input pins and the 7-segment display pins, with `none` driving the decimal point.

---
 rtl/prio_encoder_7seg_seq.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/prio_encoder_7seg_seq.sv
// Purpose : registered priority encoder (highest set bit wins) driving a hex 7-segment display, with a latch-first mode.
// Latency : SYNC_STAGES+1 rising edges from any input change to segments/none/index/change.
// Backpr. : none; free-running, pulses shorter than one clock may be missed.
// Ports   : clk, rst (async, active-high); data_in[WIDTH], mode (0 live / 1 latch-first), clear (level)
//           -> segments[6:0] (gfedcba, active-high), none (decimal point), index[IDX_W], change (1-cycle pulse).
module prio_encoder_7seg_seq #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    localparam int IDX_W      = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             mode,
    input  logic             clear,
    output logic [6:0]       segments,
    output logic             none,
    output logic [IDX_W-1:0] index,
    output logic             change
);

    localparam logic [1:0] LIVE  = 2'd0;
    localparam logic [1:0] ARMED = 2'd1;
    localparam logic [1:0] HELD  = 2'd2;

    // Synchronisers: element [0] is the first stage, [SYNC_STAGES-1] the output.
    logic [SYNC_STAGES-1:0][WIDTH-1:0] d_sync_q, d_sync_d;
    logic [SYNC_STAGES-1:0]            m_sync_q, m_sync_d;
    logic [SYNC_STAGES-1:0]            c_sync_q, c_sync_d;
    logic [WIDTH-1:0]                  d_s;
    logic                              m_s, c_s;

    logic             hit;
    logic [IDX_W-1:0] enc;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             none_q, none_d;
    logic [6:0]       seg_q, seg_d;
    logic             change_q, change_d;
    logic [3:0]       digit;

    always_comb begin
        d_sync_d = {d_sync_q[SYNC_STAGES-2:0], data_in};
        m_sync_d = {m_sync_q[SYNC_STAGES-2:0], mode};
        c_sync_d = {c_sync_q[SYNC_STAGES-2:0], clear};
    end

    assign d_s = d_sync_q[SYNC_STAGES-1];
    assign m_s = m_sync_q[SYNC_STAGES-1];
    assign c_s = c_sync_q[SYNC_STAGES-1];

    // Ascending scan so the last (highest) set bit overwrites lower ones.
    always_comb begin
        enc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (d_s[i]) enc = IDX_W'(i);
        end
    end
    assign hit = |d_s;

    // Leaving latch mode loads the live value on the same edge as the state
    // change, so a mode drop shows up with the same latency as a data change.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        none_d  = none_q;
        case (state_q)
            LIVE: begin
                idx_d  = enc;
                none_d = ~hit;
                if (m_s) state_d = ARMED;
            end
            ARMED: begin
                if (!m_s) begin
                    state_d = LIVE;
                    idx_d   = enc;
                    none_d  = ~hit;
                end else if (hit && !c_s) begin
                    state_d = HELD;
                    idx_d   = enc;
                    none_d  = 1'b0;
                end else begin
                    idx_d  = '0;
                    none_d = 1'b1;
                end
            end
            HELD: begin
                if (!m_s) begin
                    state_d = LIVE;
                    idx_d   = enc;
                    none_d  = ~hit;
                end else if (c_s) begin
                    state_d = ARMED;
                    idx_d   = '0;
                    none_d  = 1'b1;
                end
            end
            default: begin
                state_d = LIVE;
                idx_d   = '0;
                none_d  = 1'b1;
            end
        endcase
    end

    // Decoded from next-state values so segments line up with none/index.
    always_comb begin
        digit = 4'(idx_d);
        case (digit)
            4'h0: seg_d = 7'b0111111;
            4'h1: seg_d = 7'b0000110;
            4'h2: seg_d = 7'b1011011;
            4'h3: seg_d = 7'b1001111;
            4'h4: seg_d = 7'b1100110;
            4'h5: seg_d = 7'b1101101;
            4'h6: seg_d = 7'b1111101;
            4'h7: seg_d = 7'b0000111;
            4'h8: seg_d = 7'b1111111;
            4'h9: seg_d = 7'b1101111;
            4'hA: seg_d = 7'b1110111;
            4'hB: seg_d = 7'b1111100;
            4'hC: seg_d = 7'b0111001;
            4'hD: seg_d = 7'b1011110;
            4'hE: seg_d = 7'b1111001;
            default: seg_d = 7'b1110001;
        endcase
        if (none_d) seg_d = 7'b0000000;
    end

    assign change_d = ({none_d, idx_d} != {none_q, idx_q});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_sync_q <= '0;
            m_sync_q <= '0;
            c_sync_q <= '0;
            state_q  <= LIVE;
            idx_q    <= '0;
            none_q   <= 1'b1;
            seg_q    <= 7'b0000000;
            change_q <= 1'b0;
        end else begin
            d_sync_q <= d_sync_d;
            m_sync_q <= m_sync_d;
            c_sync_q <= c_sync_d;
            state_q  <= state_d;
            idx_q    <= idx_d;
            none_q   <= none_d;
            seg_q    <= seg_d;
            change_q <= change_d;
        end
    end

    assign segments = seg_q;
    assign none     = none_q;
    assign index    = idx_q;
    assign change   = change_q;

endmodule
